// File: rtl/mips_pkg.sv
// Shared MIPS definitions: register indices, register-file sweep states
// and an address-width helper.
package mips_pkg;

  localparam int unsigned ZERO = 0;
  localparam int unsigned V0   = 2;
  localparam int unsigned A0   = 4;
  localparam int unsigned T0   = 8;
  localparam int unsigned T1   = 9;
  localparam int unsigned RA   = 31;

  typedef enum logic {
    CLEAR,
    IDLE
  } rf_state_e;

  function automatic int unsigned clog2(
    input int unsigned n
  );
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered register-file read with write-first bypass.
// Ports: clk, rst_n, flush (force 0), addr, write bus (we/wa/wd), mem_data, data.
module regfile_rd_port #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned AW       = 5,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [AW-1:0]    addr,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [WIDTH-1:0] mem_data,
  output logic [WIDTH-1:0] data
);

  logic zero_hit;
  assign zero_hit = ZERO_REG && (addr == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (flush || zero_hit) begin
      data <= '0;
    end else if (we && (wa == addr)) begin
      data <= wd;
    end else begin
      data <= mem_data;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port MIPS register file: NUM_RD registered reads, general + link
// writes, clear sweep after reset/on request, v0/a0 taps for syscalls.
module regfile_mp
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter int unsigned LINK_IDX = RA,
  parameter int unsigned V0_IDX   = V0,
  parameter int unsigned A0_IDX   = A0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear_req,
  output logic                           busy,
  input  logic                           wr_en,
  input  logic [clog2(DEPTH)-1:0]        wr_addr,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           link_en,
  input  logic [WIDTH-1:0]               link_data,
  output logic                           wr_dropped,
  input  logic [NUM_RD*clog2(DEPTH)-1:0] rd_addr,
  output logic [NUM_RD*WIDTH-1:0]        rd_data,
  output logic [WIDTH-1:0]               tap_v0,
  output logic [WIDTH-1:0]               tap_a0
);

  localparam int unsigned AW = clog2(DEPTH);

  rf_state_e         state_q;
  rf_state_e         state_d;
  logic [AW-1:0]     cnt_q;
  logic              clearing;
  logic              we;
  logic [AW-1:0]     wa;
  logic [WIDTH-1:0]  wd;
  logic              drop_d;
  logic [WIDTH-1:0]  mem [DEPTH];

  assign clearing = (state_q == CLEAR);
  assign busy     = clearing;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      // wraps to 0 after DEPTH-1, so a new sweep always starts at 0
      cnt_q   <= clearing ? cnt_q + 1'b1 : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CLEAR: if (cnt_q == AW'(DEPTH - 1)) state_d = IDLE;
      IDLE:  if (clear_req) state_d = CLEAR;
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    we     = 1'b0;
    wa     = '0;
    wd     = '0;
    drop_d = 1'b0;
    priority case (1'b1)
      clearing: begin
        we     = 1'b1;
        wa     = cnt_q;
        drop_d = wr_en | link_en;
      end
      link_en: begin
        we     = 1'b1;
        wa     = AW'(LINK_IDX);
        wd     = link_data;
        drop_d = wr_en && (wr_addr != AW'(LINK_IDX));
      end
      wr_en: begin
        we = 1'b1;
        wa = wr_addr;
        wd = wr_data;
      end
      default: ;
    endcase
    if (ZERO_REG && (wa == '0)) we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_dropped <= 1'b0;
    else        wr_dropped <= drop_d;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rd_addr[k*AW +: AW];
    regfile_rd_port #(
      .WIDTH(WIDTH), .AW(AW), .ZERO_REG(ZERO_REG)
    ) u_rd (
      .clk(clk), .rst_n(rst_n), .flush(clearing),
      .addr(a), .we(we), .wa(wa), .wd(wd),
      .mem_data(mem[a]),
      .data(rd_data[k*WIDTH +: WIDTH])
    );
  end

  logic [AW-1:0] v0_a;
  logic [AW-1:0] a0_a;
  assign v0_a = AW'(V0_IDX);
  assign a0_a = AW'(A0_IDX);

  regfile_rd_port #(
    .WIDTH(WIDTH), .AW(AW), .ZERO_REG(ZERO_REG)
  ) u_tap_v0 (
    .clk(clk), .rst_n(rst_n), .flush(clearing),
    .addr(v0_a), .we(we), .wa(wa), .wd(wd),
    .mem_data(mem[v0_a]), .data(tap_v0)
  );

  regfile_rd_port #(
    .WIDTH(WIDTH), .AW(AW), .ZERO_REG(ZERO_REG)
  ) u_tap_a0 (
    .clk(clk), .rst_n(rst_n), .flush(clearing),
    .addr(a0_a), .we(we), .wa(wa), .wd(wd),
    .mem_data(mem[a0_a]), .data(tap_a0)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp against an array-level reference model.
// Two builds: zero register enabled (main) and disabled (entry-0 check).
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear_req = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        link_en = 1'b0;
  logic [31:0] link_data = '0;
  logic [4:0]  ra0 = '0;
  logic [4:0]  ra1 = '0;
  logic [9:0]  rd_addr;

  logic        busy, busy_n;
  logic        drop, drop_n;
  logic [63:0] rd_data, rd_data_n;
  logic [31:0] tap_v0, tap_a0, tv0_n, ta0_n;

  assign rd_addr = {ra1, ra0};

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req),
    .busy(busy), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .link_en(link_en),
    .link_data(link_data), .wr_dropped(drop),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .tap_v0(tap_v0), .tap_a0(tap_a0)
  );

  regfile_mp #(.ZERO_REG(1'b0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req),
    .busy(busy_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .link_en(link_en),
    .link_data(link_data), .wr_dropped(drop_n),
    .rd_addr(rd_addr), .rd_data(rd_data_n),
    .tap_v0(tv0_n), .tap_a0(ta0_n)
  );

  int checks = 0;
  int errors = 0;

  // reference model: contents as seen by software
  logic [31:0] mz [32];
  logic [31:0] mn [32];
  int          sweep_left = 0;
  logic [31:0] e_rd0, e_rd1, e_v0, e_a0, e_nz0;
  logic        e_drop;

  task automatic idle_in();
    wr_en = 1'b0;
    link_en = 1'b0;
    clear_req = 1'b0;
  endtask

  // advance one clock, predicting outputs from the model
  task automatic cyc();
    if (sweep_left > 0) begin
      mz[32-sweep_left] = '0;
      mn[32-sweep_left] = '0;
      sweep_left--;
      e_drop = wr_en | link_en;
      e_rd0 = '0; e_rd1 = '0;
      e_v0 = '0; e_a0 = '0; e_nz0 = '0;
    end else begin
      e_drop = 1'b0;
      if (link_en) begin
        mz[31] = link_data;
        mn[31] = link_data;
        e_drop = wr_en && (wr_addr != 5'd31);
      end else if (wr_en) begin
        mn[wr_addr] = wr_data;
        if (wr_addr != 5'd0) mz[wr_addr] = wr_data;
      end
      e_rd0 = mz[ra0];
      e_rd1 = mz[ra1];
      e_v0  = mz[2];
      e_a0  = mz[4];
      e_nz0 = mn[ra0];
      if (clear_req) sweep_left = 32;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int nb;
    #3;
    checks++;
    if (busy !== 1'b1 || drop !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl busy=%b drop=%b need 1 0",
               busy, drop);
    end
    checks++;
    if (rd_data !== 64'd0 || tap_v0 !== 32'd0 ||
        tap_a0 !== 32'd0) begin
      errors++;
      $display("FAIL reset_data rd=%h v0=%h a0=%h need 0",
               rd_data, tap_v0, tap_a0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sweep_left = 32;
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) nb++;
      cyc();
    end
    checks++;
    if (nb != 32) begin
      errors++;
      $display("FAIL sweep_len got %0d need 32", nb);
    end
    for (int i = 0; i < 32; i += 2) begin
      ra0 = 5'(i);
      ra1 = 5'(i + 1);
      cyc();
      checks++;
      if (rd_data !== 64'd0) begin
        errors++;
        $display("FAIL cleared_rd idx=%0d got %h need 0",
                 i, rd_data);
      end
    end
  endtask

  task automatic test_bypass();
    wr_en = 1'b1; wr_addr = 5'd8;
    wr_data = 32'hDEADBEEF; ra0 = 5'd8;
    cyc();
    idle_in();
    checks++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL bypass got %h need deadbeef",
               rd_data[31:0]);
    end
    cyc();
    cyc();
    checks++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL reread got %h need deadbeef",
               rd_data[31:0]);
    end
  endtask

  task automatic test_link();
    logic [31:0] old5;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h5555_0005;
    cyc();
    old5 = 32'h5555_0005;
    link_en = 1'b1; link_data = 32'h0040_0020;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = $urandom;
    ra0 = 5'd31; ra1 = 5'd5;
    cyc();
    idle_in();
    checks++;
    if (drop !== 1'b1) begin
      errors++;
      $display("FAIL link_drop got %b need 1", drop);
    end
    checks++;
    if (rd_data[31:0] !== 32'h0040_0020 ||
        rd_data[63:32] !== old5) begin
      errors++;
      $display("FAIL link_data ra=%h r5=%h need 00400020 %h",
               rd_data[31:0], rd_data[63:32], old5);
    end
    cyc();
    checks++;
    if (drop !== 1'b0) begin
      errors++;
      $display("FAIL drop_pulse got %b need 0", drop);
    end
    link_en = 1'b1; link_data = 32'h0040_0040;
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h1111;
    cyc();
    idle_in();
    checks++;
    if (drop !== 1'b0 || rd_data[31:0] !== 32'h0040_0040) begin
      errors++;
      $display("FAIL link_ra drop=%b ra=%h need 0 00400040",
               drop, rd_data[31:0]);
    end
  endtask

  task automatic test_zero();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
    ra0 = 5'd0;
    cyc();
    idle_in();
    checks++;
    if (rd_data[31:0] !== 32'd0 || drop !== 1'b0) begin
      errors++;
      $display("FAIL zero_reg rd=%h drop=%b need 0 0",
               rd_data[31:0], drop);
    end
    checks++;
    if (rd_data_n[31:0] !== 32'h1234) begin
      errors++;
      $display("FAIL nozero_reg rd=%h need 1234",
               rd_data_n[31:0]);
    end
  endtask

  task automatic test_taps();
    int nb;
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'd10;
    cyc();
    checks++;
    if (tap_v0 !== 32'd10) begin
      errors++;
      $display("FAIL tap_v0 got %h need a", tap_v0);
    end
    wr_addr = 5'd4; wr_data = 32'h55;
    cyc();
    idle_in();
    checks++;
    if (tap_a0 !== 32'h55) begin
      errors++;
      $display("FAIL tap_a0 got %h need 55", tap_a0);
    end
    clear_req = 1'b1;
    cyc();
    nb = 0;
    for (int i = 0; i < 34; i++) begin
      clear_req = 1'($urandom_range(0, 1));
      wr_en = (i == 5);
      wr_addr = 5'd2; wr_data = 32'hBAD;
      if (i >= 32) clear_req = 1'b0;
      if (busy) nb++;
      cyc();
      checks++;
      if (tap_v0 !== e_v0 || tap_a0 !== e_a0 ||
          drop !== e_drop) begin
        errors++;
        $display("FAIL sweep_out i=%0d v0=%h a0=%h dr=%b need %h %h %b",
                 i, tap_v0, tap_a0, drop, e_v0, e_a0, e_drop);
      end
    end
    idle_in();
    checks++;
    if (nb != 32 || tap_v0 !== 32'd0 || tap_a0 !== 32'd0) begin
      errors++;
      $display("FAIL clear_req busy=%0d v0=%h a0=%h need 32 0 0",
               nb, tap_v0, tap_a0);
    end
  endtask

  task automatic test_mid_reset();
    int nb;
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_en = (i == 9);
      cyc();
    end
    idle_in();
    checks++;
    if (drop !== 1'b1) begin
      errors++;
      $display("FAIL mid_drop got %b need 1", drop);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (drop !== 1'b0 || busy !== 1'b1 ||
        rd_data !== 64'd0 || tap_v0 !== 32'd0) begin
      errors++;
      $display("FAIL async_rst drop=%b busy=%b rd=%h need 0 1 0",
               drop, busy, rd_data);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sweep_left = 32;
    nb = 0;
    for (int i = 0; i < 36; i++) begin
      if (busy) nb++;
      cyc();
    end
    checks++;
    if (nb != 32) begin
      errors++;
      $display("FAIL restart_len got %0d need 32", nb);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      wr_en     = ($urandom_range(0, 1) == 1);
      wr_addr   = 5'($urandom);
      wr_data   = $urandom;
      link_en   = ($urandom_range(0, 4) == 0);
      link_data = $urandom;
      clear_req = ($urandom_range(0, 99) == 0);
      ra0       = 5'($urandom);
      ra1       = ($urandom_range(0, 3) == 0) ? wr_addr
                                              : 5'($urandom);
      cyc();
      checks++;
      if (rd_data[31:0] !== e_rd0 || rd_data[63:32] !== e_rd1) begin
        errors++;
        $display("FAIL rnd_rd i=%0d got %h %h need %h %h",
                 i, rd_data[31:0], rd_data[63:32], e_rd0, e_rd1);
      end
      checks++;
      if (tap_v0 !== e_v0 || tap_a0 !== e_a0) begin
        errors++;
        $display("FAIL rnd_tap i=%0d got %h %h need %h %h",
                 i, tap_v0, tap_a0, e_v0, e_a0);
      end
      checks++;
      if (drop !== e_drop || busy !== (sweep_left > 0)) begin
        errors++;
        $display("FAIL rnd_ctl i=%0d drop=%b busy=%b need %b %b",
                 i, drop, busy, e_drop, sweep_left > 0);
      end
      checks++;
      if (rd_data_n[31:0] !== e_nz0) begin
        errors++;
        $display("FAIL rnd_nz i=%0d got %h need %h",
                 i, rd_data_n[31:0], e_nz0);
      end
    end
    idle_in();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_link();
    test_zero();
    test_taps();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
